multicycle_ctrl_v4: RTL and testbench

Parametrised successor to the multi-cycle processor control FSM. It sequences fetch, decode, execute and writeback for the 4-bit-opcode ISA, and adds four things: memory wait states via `mem_ready`, a resumable STOP, a sticky illegal-opcode trap, and optional saturating performance counters. It sits between the instruction register and the datapath, driving the same control signal set the datapath already consumes.

---
 rtl/multicycle_ctrl_v4.sv | 262 ++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_v4.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_v4.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_v4
//
// Control FSM for the multi-cycle 4-bit-opcode processor. It sequences
// fetch / decode / execute / writeback and adds:
//   - memory wait states via mem_ready (FETCH, LD_MEM, ST_MEM),
//   - a resumable STOP state (exit on run),
//   - a sticky TRAP state for illegal opcodes (exit on reset only),
//   - optional saturating performance counters.
//
// Configuration macro:
//   MULTICYCLE_PERF_CNT_EN  defined   -> cycle_count / instr_count implemented
//                           undefined -> no counter flops, counters tie to 0
//
// Parameters:
//   OPW    opcode width (>= 4); bits [OPW-1:4] must be zero for a legal opcode
//   CNT_W  width of each performance counter
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   instr        in   opcode field of the IR
//   N, Z         in   ALU flags
//   mem_ready    in   memory completes the current access this cycle
//   run          in   resumes execution from STOP
//   PCwrite .. FlagWrite  out  1-bit datapath controls
//   ALU2, ALUop  out  ALU operand-B select, ALU operation
//   halted       out  FSM is in STOP
//   illegal      out  FSM is in TRAP
//   cycle_count, instr_count  out  performance counters
// ---------------------------------------------------------------------------
module multicycle_ctrl_v4 #(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [OPW-1:0]   instr,
    input  logic             N,
    input  logic             Z,
    input  logic             mem_ready,
    input  logic             run,
    output logic             PCwrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRload,
    output logic             R1Sel,
    output logic             MDRload,
    output logic             R1R2Load,
    output logic             ALU1,
    output logic             ALUOutWrite,
    output logic             RFWrite,
    output logic             RegIn,
    output logic             FlagWrite,
    output logic [2:0]       ALU2,
    output logic [2:0]       ALUop,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_ASN,
        S_SHIFT,
        S_WB,
        S_ORI_RD,
        S_ORI_EX,
        S_ORI_WB,
        S_LD_MEM,
        S_LD_WB,
        S_ST_MEM,
        S_BR,
        S_STOP,
        S_TRAP
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] op;
    logic       op_hi_nz;

    assign op = instr[3:0];

    // Upper opcode bits only exist when OPW > 4; any set bit there is illegal.
    generate
        if (OPW > 4) begin : g_hi
            assign op_hi_nz = |instr[OPW-1:4];
        end else begin : g_no_hi
            assign op_hi_nz = 1'b0;
        end
    endgenerate

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op_hi_nz) begin
                    state_d = S_TRAP;
                end else begin
                    casez (op)
                        4'b0100, 4'b0110, 4'b1000: state_d = S_ASN;
                        4'b?011:                   state_d = S_SHIFT;
                        4'b?111:                   state_d = S_ORI_RD;
                        4'b0000:                   state_d = S_LD_MEM;
                        4'b0010:                   state_d = S_ST_MEM;
                        4'b1101, 4'b0101, 4'b1001: state_d = S_BR;
                        4'b1010:                   state_d = S_FETCH;
                        4'b0001:                   state_d = S_STOP;
                        default:                   state_d = S_TRAP;
                    endcase
                end
            end
            S_ASN:    state_d = S_WB;
            S_SHIFT:  state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_ORI_RD: state_d = S_ORI_EX;
            S_ORI_EX: state_d = S_ORI_WB;
            S_ORI_WB: state_d = S_FETCH;
            S_LD_MEM: state_d = mem_ready ? S_LD_WB : S_LD_MEM;
            S_LD_WB:  state_d = S_FETCH;
            S_ST_MEM: state_d = mem_ready ? S_FETCH : S_ST_MEM;
            S_BR:     state_d = S_FETCH;
            S_STOP:   state_d = run ? S_FETCH : S_STOP;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_RST;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        PCwrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRload      = 1'b0;
        R1Sel       = 1'b0;
        MDRload     = 1'b0;
        R1R2Load    = 1'b0;
        ALU1        = 1'b0;
        ALUOutWrite = 1'b0;
        RFWrite     = 1'b0;
        RegIn       = 1'b0;
        FlagWrite   = 1'b0;
        ALU2        = 3'b000;
        ALUop       = 3'b000;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALU2    = 3'b001;
                PCwrite = mem_ready;
                IRload  = mem_ready;
            end
            S_DECODE: R1R2Load = 1'b1;
            S_ASN: begin
                ALU1        = 1'b1;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
                case (op)
                    4'b0110: ALUop = 3'b001;
                    4'b1000: ALUop = 3'b011;
                    default: ALUop = 3'b000;
                endcase
            end
            S_SHIFT: begin
                ALU1        = 1'b1;
                ALU2        = 3'b100;
                ALUop       = 3'b100;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
            end
            S_WB: RFWrite = 1'b1;
            S_ORI_RD: begin
                R1Sel    = 1'b1;
                R1R2Load = 1'b1;
            end
            S_ORI_EX: begin
                ALU1        = 1'b1;
                ALU2        = 3'b011;
                ALUop       = 3'b010;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
            end
            S_ORI_WB: begin
                R1Sel   = 1'b1;
                RFWrite = 1'b1;
            end
            S_LD_MEM: begin
                MemRead = 1'b1;
                MDRload = mem_ready;
            end
            S_LD_WB: begin
                RegIn       = 1'b1;
                RFWrite     = 1'b1;
                ALUOutWrite = 1'b1;
            end
            S_ST_MEM: MemWrite = 1'b1;
            S_BR: begin
                ALU2 = 3'b010;
                // bpz: 1101, bz: 0101, bnz: 1001
                case (op)
                    4'b1101: PCwrite = ~N;
                    4'b0101: PCwrite = Z;
                    4'b1001: PCwrite = ~Z;
                    default: PCwrite = 1'b0;
                endcase
            end
            S_STOP:  halted  = 1'b1;
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    // ---------------- performance counters ----------------
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ins_q;
    logic             cyc_en;
    logic             ins_en;

    assign cyc_en = (state_q != S_RST) && (state_q != S_STOP) && (state_q != S_TRAP);
    assign ins_en = (state_q == S_FETCH) && mem_ready;

    // Counters hold at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (cyc_en && (cyc_q != '1)) begin
                cyc_q <= cyc_q + 1'b1;
            end
            if (ins_en && (ins_q != '1)) begin
                ins_q <= ins_q + 1'b1;
            end
        end
    end

    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_v4.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_v4
//
// Directed self-checking bench for multicycle_ctrl_v4 (OPW=6, CNT_W=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Control outputs are compared as one packed word:
//   {PCwrite,MemRead,MemWrite,IRload,R1Sel,MDRload,R1R2Load,ALU1,
//    ALUOutWrite,RFWrite,RegIn,FlagWrite, ALU2[2:0], ALUop[2:0], halted, illegal}
// Counter expectations depend on MULTICYCLE_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_v4;

    localparam int OPW   = 6;
    localparam int CNT_W = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [OPW-1:0] instr = '0;
    logic           N = 1'b0;
    logic           Z = 1'b0;
    logic           mem_ready = 1'b0;
    logic           run = 1'b0;

    logic PCwrite, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load;
    logic ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, halted, illegal;
    logic [2:0] ALU2, ALUop;
    logic [CNT_W-1:0] cycle_count, instr_count;
    logic [19:0] ctl;

    int checks   = 0;
    int failures = 0;

    localparam logic [19:0] C_IDLE  = 20'h0;
    localparam logic [19:0] C_FETCH = {12'b1101_0000_0000, 3'b001, 3'b000, 2'b00};
    localparam logic [19:0] C_FWAIT = {12'b0100_0000_0000, 3'b001, 3'b000, 2'b00};
    localparam logic [19:0] C_DEC   = {12'b0000_0010_0000, 3'b000, 3'b000, 2'b00};
    localparam logic [19:0] C_ADD   = {12'b0000_0001_1001, 3'b000, 3'b000, 2'b00};
    localparam logic [19:0] C_SUB   = {12'b0000_0001_1001, 3'b000, 3'b001, 2'b00};
    localparam logic [19:0] C_NAND  = {12'b0000_0001_1001, 3'b000, 3'b011, 2'b00};
    localparam logic [19:0] C_SHIFT = {12'b0000_0001_1001, 3'b100, 3'b100, 2'b00};
    localparam logic [19:0] C_WB    = {12'b0000_0000_0100, 3'b000, 3'b000, 2'b00};
    localparam logic [19:0] C_ORD   = {12'b0000_1010_0000, 3'b000, 3'b000, 2'b00};
    localparam logic [19:0] C_OEX   = {12'b0000_0001_1001, 3'b011, 3'b010, 2'b00};
    localparam logic [19:0] C_OWB   = {12'b0000_1000_0100, 3'b000, 3'b000, 2'b00};
    localparam logic [19:0] C_LDW   = {12'b0100_0000_0000, 3'b000, 3'b000, 2'b00};
    localparam logic [19:0] C_LDR   = {12'b0100_0100_0000, 3'b000, 3'b000, 2'b00};
    localparam logic [19:0] C_LWB   = {12'b0000_0000_1110, 3'b000, 3'b000, 2'b00};
    localparam logic [19:0] C_ST    = {12'b0010_0000_0000, 3'b000, 3'b000, 2'b00};
    localparam logic [19:0] C_BR0   = {12'b0000_0000_0000, 3'b010, 3'b000, 2'b00};
    localparam logic [19:0] C_BR1   = {12'b1000_0000_0000, 3'b010, 3'b000, 2'b00};
    localparam logic [19:0] C_STOP  = 20'b10;
    localparam logic [19:0] C_TRAP  = 20'b01;

    multicycle_ctrl_v4 #(.OPW(OPW), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .N           (N),
        .Z           (Z),
        .mem_ready   (mem_ready),
        .run         (run),
        .PCwrite     (PCwrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRload      (IRload),
        .R1Sel       (R1Sel),
        .MDRload     (MDRload),
        .R1R2Load    (R1R2Load),
        .ALU1        (ALU1),
        .ALUOutWrite (ALUOutWrite),
        .RFWrite     (RFWrite),
        .RegIn       (RegIn),
        .FlagWrite   (FlagWrite),
        .ALU2        (ALU2),
        .ALUop       (ALUop),
        .halted      (halted),
        .illegal     (illegal),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    assign ctl = {PCwrite, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load,
                  ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, ALU2, ALUop,
                  halted, illegal};

    always #5 clock = ~clock;

    // Expected counter value after n counted events (saturating 4-bit).
    function automatic logic [3:0] ce(input int n);
        int v;
        v = (n > 15) ? 15 : n;
`ifndef MULTICYCLE_PERF_CNT_EN
        v = 0;
`endif
        return v[3:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic at(input string tag, input logic [19:0] e);
        #1;
        chk(tag, {12'b0, ctl}, {12'b0, e});
    endtask

    task automatic cnt(input string tag, input int c, input int i);
        chk({tag, "_cycle_count"}, {28'b0, cycle_count}, {28'b0, ce(c)});
        chk({tag, "_instr_count"}, {28'b0, instr_count}, {28'b0, ce(i)});
    endtask

    // Asserts reset mid-cycle (checks the asynchronous clear), then releases
    // it on the next falling edge; the DUT sits in RST for that cycle.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "_async_ctl"}, {12'b0, ctl}, 32'h0);
        chk({tag, "_async_cc"}, {28'b0, cycle_count}, 32'h0);
        chk({tag, "_async_ic"}, {28'b0, instr_count}, 32'h0);
        tick();
        reset = 1'b1;
        at({tag, "_rst_hold"}, C_IDLE);
    endtask

    initial begin
        // ---- power-on reset, asynchronous, before any clock edge ----
        #2;
        reset = 1'b0;
        #1;
        chk("por_ctl", {12'b0, ctl}, 32'h0);
        cnt("por", 0, 0);

        tick(); reset = 1'b1; instr = 6'h04; mem_ready = 1'b1;
        at("por_rst_hold", C_IDLE);

        // ---- add ----
        tick(); at("add_fetch", C_FETCH); cnt("add_fetch", 0, 0);
        tick(); at("add_dec", C_DEC);     cnt("add_dec", 1, 1);
        tick(); at("add_asn", C_ADD);
        tick(); at("add_wb", C_WB);       cnt("add_wb", 3, 1);
        // ---- sub ----
        tick(); instr = 6'h06; at("sub_fetch", C_FETCH);
        tick(); at("sub_dec", C_DEC);
        tick(); at("sub_asn", C_SUB);
        tick(); at("sub_wb", C_WB);
        // ---- nand ----
        tick(); instr = 6'h08; at("nand_fetch", C_FETCH);
        tick(); at("nand_dec", C_DEC);
        tick(); at("nand_asn", C_NAND);
        tick(); at("nand_wb", C_WB);
        // ---- shift (1011) ----
        tick(); instr = 6'h0B; at("shift_fetch", C_FETCH);
        tick(); at("shift_dec", C_DEC);
        tick(); at("shift_ex", C_SHIFT);
        tick(); at("shift_wb", C_WB);
        // ---- ori (0111) ----
        tick(); instr = 6'h07; at("ori_fetch", C_FETCH);
        tick(); at("ori_dec", C_DEC);
        tick(); at("ori_rd", C_ORD);
        tick(); at("ori_ex", C_OEX);
        tick(); at("ori_wb", C_OWB);
        // ---- nop: two cycles ----
        tick(); instr = 6'h0A; at("nop_fetch", C_FETCH);
        tick(); at("nop_dec", C_DEC);

        // ---- load with three wait cycles in LD_MEM: 7 cycles total ----
        tick(); instr = 6'h00; at("ld_fetch", C_FETCH);
        tick(); at("ld_dec", C_DEC);
        tick(); mem_ready = 1'b0; at("ld_mem_w1", C_LDW);
        tick(); at("ld_mem_w2", C_LDW);
        tick(); at("ld_mem_w3", C_LDW);
        tick(); mem_ready = 1'b1; at("ld_mem_rdy", C_LDR);
        tick(); at("ld_wb", C_LWB);

        // ---- fetch wait state, then store with one wait ----
        tick(); instr = 6'h02; mem_ready = 1'b0; at("st_fetch_wait", C_FWAIT);
        tick(); mem_ready = 1'b1; at("st_fetch", C_FETCH);
        tick(); at("st_dec", C_DEC);
        tick(); mem_ready = 1'b0; at("st_mem_w", C_ST);
        tick(); mem_ready = 1'b1; at("st_mem_rdy", C_ST);

        // ---- bz with Z=0, then Z=1 ----
        tick(); instr = 6'h05; Z = 1'b0; at("bz0_fetch", C_FETCH);
        tick(); at("bz0_dec", C_DEC);
        tick(); at("bz0_br", C_BR0);
        tick(); at("bz1_fetch", C_FETCH);
        tick(); at("bz1_dec", C_DEC);
        tick(); Z = 1'b1; at("bz1_br", C_BR1);
        // ---- bnz with Z=1: not taken ----
        tick(); instr = 6'h09; at("bnz_fetch", C_FETCH);
        tick(); at("bnz_dec", C_DEC);
        tick(); at("bnz_br", C_BR0);
        // ---- bpz with N=0 (taken), then N=1 (not taken) ----
        tick(); instr = 6'h0D; N = 1'b0; at("bpz0_fetch", C_FETCH);
        tick(); at("bpz0_dec", C_DEC);
        tick(); at("bpz0_br", C_BR1);
        tick(); at("bpz1_fetch", C_FETCH);
        tick(); at("bpz1_dec", C_DEC);
        tick(); N = 1'b1; at("bpz1_br", C_BR0);

        // ---- reset during a pending load aborts without stray pulses ----
        tick(); instr = 6'h00; N = 1'b0; Z = 1'b0; at("abort_fetch", C_FETCH);
        tick(); at("abort_dec", C_DEC);
        tick(); mem_ready = 1'b0; at("abort_ldw", C_LDW);
        #2; reset = 1'b0; #1; mem_ready = 1'b1; #1;
        chk("abort_ctl", {12'b0, ctl}, 32'h0);
        tick(); reset = 1'b1; instr = 6'h01; at("abort_rst_hold", C_IDLE);

        // ---- STOP: halted, counters frozen, resumed by run ----
        tick(); at("stop_fetch", C_FETCH); cnt("stop_fetch", 0, 0);
        tick(); at("stop_dec", C_DEC);
        tick(); at("stop_s1", C_STOP); cnt("stop_s1", 2, 1);
        tick(); at("stop_s2", C_STOP);
        tick(); at("stop_s3", C_STOP);
        tick(); at("stop_s4", C_STOP); cnt("stop_s4", 2, 1);
        tick(); run = 1'b1; at("stop_run", C_STOP);
        tick(); run = 1'b0; instr = 6'h0A; at("stop_exit_fetch", C_FETCH);
        cnt("stop_exit", 2, 1);
        tick(); at("stop_exit_dec", C_DEC);

        // ---- TRAP on nonzero upper opcode bits: sticky for 20 cycles ----
        do_reset("trap_hi");
        instr = 6'h1F;
        tick(); at("traphi_fetch", C_FETCH);
        tick(); at("traphi_dec", C_DEC);
        run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(); at("traphi_hold", C_TRAP);
        end
        run = 1'b0;
        cnt("traphi_frozen", 2, 1);
        do_reset("trap_clear");

        // ---- TRAP on undefined low opcode 1100 ----
        instr = 6'h0C;
        tick(); at("traplo_fetch", C_FETCH);
        tick(); at("traplo_dec", C_DEC);
        tick(); at("traplo_trap", C_TRAP);
        tick(); at("traplo_hold", C_TRAP);
        do_reset("sat");

        // ---- counter saturation with back-to-back nops ----
        instr = 6'h0A;
        for (int k = 0; k < 40; k++) begin
            tick();
            at("sat_seq", (k % 2 == 0) ? C_FETCH : C_DEC);
            if (k == 14) cnt("sat_k14", 14, 7);
            if (k == 16) cnt("sat_k16", 16, 8);
            if (k == 39) cnt("sat_k39", 39, 20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
